load_store_unit: RTL and testbench

//   CPU-side initiator for the byte-write-enabled, synchronous-read data RAM port.

---
 rtl/load_store_unit.sv | 151 +++++++++++++++
 tb/tb_load_store_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: CPU-side initiator for a byte-write-enabled, synchronous-read
// data RAM port. Takes one load/store at a time, presents the registered word
// address / byte enables / lane-replicated write data for one cycle, waits
// RD_LATENCY edges for load data, then returns a one-cycle response.
// Optional build macro: LSU_MISALIGN_EXC_EN. When it is defined, misaligned
// half/word accesses are reported as errors. When it is undefined, the low
// address bits that cause the misalignment are ignored.
module load_store_unit #(
    parameter int XLEN       = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [3:0]      mem_wea,
    output logic [XLEN-3:0] mem_addra,
    output logic [XLEN-1:0] mem_dina,
    input  logic [XLEN-1:0] mem_douta
);

    typedef enum logic [1:0] {IDLE, ACCESS, DATA, RESP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q;
    logic [1:0]  a_q;
    logic [2:0]  f3_q;
    logic        we_q;
    logic        accept;
    logic        illegal;
    logic        misaligned;
    logic        req_err;

    // Byte enables for a store, placed on the lanes selected by the low address bits.
    function automatic logic [3:0] store_wea(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << {a[1], 1'b0};
            default: return 4'hF;
        endcase
    endfunction

    // Write data replicated across all lanes so the enables alone pick the target.
    function automatic logic [XLEN-1:0] store_dina(input logic [2:0] f3, input logic [XLEN-1:0] wd);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    // Extract the addressed byte/half from the RAM word and sign- or zero-extend it.
    function automatic logic [XLEN-1:0] load_format(input logic [2:0] f3, input logic [1:0] a,
                                                    input logic [XLEN-1:0] dout);
        logic        [7:0]      b;
        logic        [15:0]     h;
        logic signed [7:0]      b_s;
        logic signed [15:0]     h_s;
        logic signed [XLEN-1:0] ext;
        b   = dout[{a, 3'b000} +: 8];
        h   = dout[{a[1], 4'b0000} +: 16];
        b_s = $signed(b);
        h_s = $signed(h);
        case (f3)
            3'b000:  begin ext = b_s; return $unsigned(ext); end
            3'b001:  begin ext = h_s; return $unsigned(ext); end
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return dout;
        endcase
    endfunction

    assign accept  = req_valid & req_ready;
    assign illegal = req_we ? (req_funct3[2] | (req_funct3[1:0] == 2'b11))
                            : ((req_funct3 == 3'b011) | (req_funct3 == 3'b110) | (req_funct3 == 3'b111));
`ifdef LSU_MISALIGN_EXC_EN
    assign misaligned = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                        ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif
    assign req_err = illegal | misaligned;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: errors skip the RAM entirely, stores finish after ACCESS.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = req_err ? RESP : ACCESS;
            ACCESS:  state_d = we_q ? RESP : DATA;
            DATA:    if (cnt_q == 2'd0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
    end

    // Read-latency down-counter: loaded in ACCESS, reaches zero on the last DATA cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    cnt_q <= 2'd0;
        else if (state_q == ACCESS) cnt_q <= 2'(RD_LATENCY - 1);
        else if (state_q == DATA)   cnt_q <= cnt_q - 2'd1;
    end

    // Request capture, RAM port drive and response data; wea lives for ACCESS only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q        <= 2'b00;
            f3_q       <= 3'b000;
            we_q       <= 1'b0;
            mem_wea    <= 4'h0;
            mem_addra  <= '0;
            mem_dina   <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            mem_wea <= 4'h0;
            if (accept) begin
                a_q        <= req_addr[1:0];
                f3_q       <= req_funct3;
                we_q       <= req_we;
                mem_addra  <= req_addr[XLEN-1:2];
                mem_dina   <= store_dina(req_funct3, req_wdata);
                resp_rdata <= '0;
                resp_err   <= req_err;
                if (req_we && !req_err)
                    mem_wea <= store_wea(req_funct3, req_addr[1:0]);
            end else if (state_q == DATA && cnt_q == 2'd0) begin
                resp_rdata <= load_format(f3_q, a_q, mem_douta);
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed test of load_store_unit against a small
// byte-write-enabled, read-first RAM model with a configurable read latency.
module tb_load_store_unit;

    parameter int RDL = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [3:0]  mem_wea;
    logic [29:0] mem_addra;
    logic [31:0] mem_dina;
    logic [31:0] mem_douta;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    load_store_unit #(.XLEN(32), .RD_LATENCY(RDL)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_wea(mem_wea), .mem_addra(mem_addra), .mem_dina(mem_dina),
        .mem_douta(mem_douta)
    );

    always #5 clk = ~clk;

    // RAM model: 16 words, byte writes, read-first, RDL-stage read pipeline.
    logic [31:0] ram [16] = '{default: 32'h0};
    logic [31:0] rd_pipe [RDL];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (mem_wea[b]) ram[mem_addra[3:0]][8*b +: 8] <= mem_dina[8*b +: 8];
        rd_pipe[0] <= ram[mem_addra[3:0]];
        for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_douta = rd_pipe[RDL-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction: drive, check the ACCESS-cycle RAM port, wait for
    // the response within a bounded number of edges, check latency and payload.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input logic [3:0] exp_wea, input logic [31:0] exp_dina,
                          input int lat);
        int   w;
        int   n;
        exp_t e;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 20) begin @(negedge clk); w++; end
        chk({tag, "_ready_in"}, {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        sb.push_back('{exp_rdata, exp_err, lat});
        @(posedge clk); #1;
        // scramble request fields: the DUT must have latched what it needs
        req_valid  = 1'b0;
        req_we     = ~we;
        req_funct3 = ~f3;
        req_addr   = ~addr;
        req_wdata  = ~wdata;
        chk({tag, "_wea"}, {28'b0, mem_wea}, {28'b0, exp_wea});
        chk({tag, "_ready_busy"}, {31'b0, req_ready}, 32'd0);
        if (!exp_err) chk({tag, "_addra"}, {2'b0, mem_addra}, {2'b0, addr[31:2]});
        if (we && !exp_err) chk({tag, "_dina"}, mem_dina, exp_dina);
        n = 0;
        while (!resp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
            chk({tag, "_wea_after"}, {28'b0, mem_wea}, 32'd0);
        end
        chk({tag, "_latency"}, n, lat);
        if (resp_valid && sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_rdata"}, resp_rdata, e.rdata);
            chk({tag, "_err"}, {31'b0, resp_err}, {31'b0, e.err});
        end
        @(posedge clk); #1;
        chk({tag, "_resp_pulse"}, {31'b0, resp_valid}, 32'd0);
        chk({tag, "_ready_back"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        #1;
        chk("rst_wea",   {28'b0, mem_wea}, 32'd0);
        chk("rst_addra", {2'b0, mem_addra}, 32'd0);
        chk("rst_dina",  mem_dina, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err",   {31'b0, resp_err}, 32'd0);
        chk("rst_valid", {31'b0, resp_valid}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rst_ready", {31'b0, req_ready}, 32'd1);

        // Stores: word, then a byte into lane 3
        do_req("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 4'hF, 32'hDEADBEEF, 1);
        do_req("sb13", 1'b1, 3'b000, 32'h13, 32'h000000A5, 32'h0, 1'b0, 4'b1000, 32'hA5A5A5A5, 1);
        do_req("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hA5ADBEEF, 1'b0, 4'h0, 32'h0, 1 + RDL);

        // Loads with extraction and extension
        do_req("lb13",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFA5, 1'b0, 4'h0, 32'h0, 1 + RDL);
        do_req("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000A5, 1'b0, 4'h0, 32'h0, 1 + RDL);
        do_req("lh12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFA5AD, 1'b0, 4'h0, 32'h0, 1 + RDL);
        do_req("lhu10", 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, 4'h0, 32'h0, 1 + RDL);

        // Halfword store to the upper lanes, then read back
        do_req("sh16", 1'b1, 3'b001, 32'h16, 32'h00001234, 32'h0, 1'b0, 4'b1100, 32'h12341234, 1);
        do_req("lw14", 1'b0, 3'b010, 32'h14, 32'h0, 32'h12340000, 1'b0, 4'h0, 32'h0, 1 + RDL);
        do_req("lh16", 1'b0, 3'b001, 32'h16, 32'h0, 32'h00001234, 1'b0, 4'h0, 32'h0, 1 + RDL);
        do_req("lb14", 1'b0, 3'b000, 32'h14, 32'h0, 32'h00000000, 1'b0, 4'h0, 32'h0, 1 + RDL);

        // Misaligned word load
`ifdef LSU_MISALIGN_EXC_EN
        do_req("lw11", 1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, 0);
        do_req("sh11", 1'b1, 3'b001, 32'h11, 32'hFFFF, 32'h0, 1'b1, 4'h0, 32'h0, 0);
`else
        do_req("lw11", 1'b0, 3'b010, 32'h11, 32'h0, 32'hA5ADBEEF, 1'b0, 4'h0, 32'h0, 1 + RDL);
        do_req("lh11", 1'b0, 3'b001, 32'h11, 32'h0, 32'hFFFFBEEF, 1'b0, 4'h0, 32'h0, 1 + RDL);
`endif

        // Illegal funct3 on a load and on a store
        do_req("ld011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, 0);
        do_req("st100", 1'b1, 3'b100, 32'h10, 32'h0, 32'h0, 1'b1, 4'h0, 32'h0, 0);
        do_req("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 32'hA5ADBEEF, 1'b0, 4'h0, 32'h0, 1 + RDL);

        // Reset during ACCESS of a store: write dropped, no response
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        req_wdata  = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rstmid_wea_set", {28'b0, mem_wea}, 32'h0000000F);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_wea_clr", {28'b0, mem_wea}, 32'd0);
        chk("rstmid_valid",   {31'b0, resp_valid}, 32'd0);
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("rstmid_no_resp", {31'b0, resp_valid}, 32'd0);
        end
        do_req("lw10c", 1'b0, 3'b010, 32'h10, 32'h0, 32'hA5ADBEEF, 1'b0, 4'h0, 32'h0, 1 + RDL);

        chk("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
